btb_2way_responder: RTL and testbench

- Branch target buffer that answers prediction lookups from the fetch-stage branch predictor and absorbs resolved-branch updates from writeback.
- Storage is 2-way set-associative, with one 2-bit saturating direction counter per entry and one LRU bit per set.
- Lookup is combinational, in the same cycle as IF. Update is a registered write using a ready/valid handshake.
- An invalidate request runs a multi-cycle clear sequence that sweeps the sets.

---
 rtl/btb_2way_responder_if.sv | 29 ++
 rtl/btb_2way_responder.sv | 147 ++++++++++++++
 tb/tb_btb_2way_responder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_2way_responder_if.sv
// Lookup, update and invalidate signals of the 2-way BTB.
// master = predictor/writeback side, slave = BTB.
interface btb_2way_responder_if;
   logic [15:0] lookup_pc;
   logic        lookup_hit;
   logic        lookup_taken;
   logic [15:0] lookup_target;
   logic        upd_valid;
   logic        upd_ready;
   logic [15:0] upd_pc;
   logic [15:0] upd_target;
   logic        upd_taken;
   logic        inval_req;
   logic        clearing;

   modport master (
      output lookup_pc, upd_valid, upd_pc,
      output upd_target, upd_taken, inval_req,
      input  lookup_hit, lookup_taken,
      input  lookup_target, upd_ready, clearing
   );

   modport slave (
      input  lookup_pc, upd_valid, upd_pc,
      input  upd_target, upd_taken, inval_req,
      output lookup_hit, lookup_taken,
      output lookup_target, upd_ready, clearing
   );
endinterface

// File: rtl/btb_2way_responder.sv
// 2-way set-associative branch target buffer.
// Combinational lookup, registered update, swept invalidate.
module btb_2way_responder #(
   parameter int SETS  = 8,
   parameter int IDX_W = 3
) (
   input  logic clk,
   input  logic rst,
   btb_2way_responder_if.slave bus
);
   localparam int TAG_W = 16 - 1 - IDX_W;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] clr_cnt;

   logic             valid_q [2][SETS];
   logic [TAG_W-1:0] tag_q   [2][SETS];
   logic [15:0]      tgt_q   [2][SETS];
   logic [1:0]       ctr_q   [2][SETS];
   logic             lru_q   [SETS];

   logic [IDX_W-1:0] l_idx;
   logic [TAG_W-1:0] l_tag;
   logic             l_hit0, l_hit1;

   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit0, u_hit1, u_hit;
   logic             u_way, a_way;
   logic             fire;
   logic [1:0]       ctr_cur, ctr_nxt;

   logic unused_pc_lsb;
   assign unused_pc_lsb = ^{bus.lookup_pc[0], bus.upd_pc[0]};

   assign l_idx = bus.lookup_pc[IDX_W:1];
   assign l_tag = bus.lookup_pc[15:IDX_W+1];
   assign u_idx = bus.upd_pc[IDX_W:1];
   assign u_tag = bus.upd_pc[15:IDX_W+1];

   assign bus.clearing  = (state == CLEAR);
   assign bus.upd_ready = (state == IDLE) && !rst;
   assign fire          = bus.upd_valid && bus.upd_ready;

   // Lookup: way 0 wins on a double hit; blanked while sweeping.
   always_comb begin
      bus.lookup_hit    = 1'b0;
      bus.lookup_taken  = 1'b0;
      bus.lookup_target = 16'h0000;
      l_hit0 = valid_q[0][l_idx] && (tag_q[0][l_idx] == l_tag);
      l_hit1 = valid_q[1][l_idx] && (tag_q[1][l_idx] == l_tag);
      if (state == IDLE) begin
         if (l_hit0) begin
            bus.lookup_hit    = 1'b1;
            bus.lookup_taken  = ctr_q[0][l_idx][1];
            bus.lookup_target = tgt_q[0][l_idx];
         end else if (l_hit1) begin
            bus.lookup_hit    = 1'b1;
            bus.lookup_taken  = ctr_q[1][l_idx][1];
            bus.lookup_target = tgt_q[1][l_idx];
         end
      end
   end

   // Update way select, victim choice and saturating counter step.
   always_comb begin
      u_hit0  = valid_q[0][u_idx] && (tag_q[0][u_idx] == u_tag);
      u_hit1  = valid_q[1][u_idx] && (tag_q[1][u_idx] == u_tag);
      u_hit   = u_hit0 || u_hit1;
      u_way   = !u_hit0;
      a_way   = lru_q[u_idx];
      if (!valid_q[0][u_idx]) begin
         a_way = 1'b0;
      end else if (!valid_q[1][u_idx]) begin
         a_way = 1'b1;
      end
      ctr_cur = ctr_q[u_way][u_idx];
      ctr_nxt = ctr_cur;
      if (bus.upd_taken) begin
         if (ctr_cur != 2'd3) ctr_nxt = ctr_cur + 2'd1;
      end else begin
         if (ctr_cur != 2'd0) ctr_nxt = ctr_cur - 2'd1;
      end
   end

   // Next-state logic for the invalidate sweep.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (bus.inval_req) state_nxt = CLEAR;
         CLEAR: if (clr_cnt == IDX_W'(SETS - 1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and sweep index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         clr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            clr_cnt <= '0;
         end else begin
            clr_cnt <= clr_cnt + IDX_W'(1);
         end
      end
   end

   // Table storage: sweep clears one set per cycle, else apply updates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            lru_q[s] <= 1'b0;
            for (int w = 0; w < 2; w++) begin
               valid_q[w][s] <= 1'b0;
               tag_q[w][s]   <= '0;
               tgt_q[w][s]   <= '0;
               ctr_q[w][s]   <= '0;
            end
         end
      end else if (state == CLEAR) begin
         lru_q[clr_cnt] <= 1'b0;
         for (int w = 0; w < 2; w++) begin
            valid_q[w][clr_cnt] <= 1'b0;
            ctr_q[w][clr_cnt]   <= '0;
         end
      end else if (fire) begin
         if (u_hit) begin
            ctr_q[u_way][u_idx] <= ctr_nxt;
            lru_q[u_idx]        <= ~u_way;
            if (bus.upd_taken) begin
               tgt_q[u_way][u_idx] <= bus.upd_target;
            end
         end else if (bus.upd_taken) begin
            valid_q[a_way][u_idx] <= 1'b1;
            tag_q[a_way][u_idx]   <= u_tag;
            tgt_q[a_way][u_idx]   <= bus.upd_target;
            ctr_q[a_way][u_idx]   <= 2'b10;
            lru_q[u_idx]          <= ~a_way;
         end
      end
   end
endmodule

// File: tb/tb_btb_2way_responder.sv
// Directed bench for btb_2way_responder with a recency-based
// reference model checked every negative clock edge.
module tb_btb_2way_responder;
   localparam int SETS = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   btb_2way_responder_if bus ();

   btb_2way_responder #(.SETS(SETS), .IDX_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each entry remembers the full branch PC and the
   // time it was last written or hit; the victim is the older one.
   bit          m_valid [SETS][2];
   logic [15:0] m_pc    [SETS][2];
   logic [15:0] m_tgt   [SETS][2];
   int          m_cnt   [SETS][2];
   int          m_stamp [SETS][2];
   int          now_t = 0;
   int          clr_left = 0;

   function automatic int set_of(logic [15:0] pc);
      return (int'(pc) / 2) % SETS;
   endfunction

   function automatic int find_way(logic [15:0] pc);
      int s;
      s = set_of(pc);
      for (int w = 0; w < 2; w++)
         if (m_valid[s][w] && m_pc[s][w][15:1] == pc[15:1]) return w;
      return -1;
   endfunction

   task automatic model_update(logic [15:0] pc, logic [15:0] tgt, logic tk);
      int s, w;
      s = set_of(pc);
      w = find_way(pc);
      if (w >= 0) begin
         if (tk) begin
            m_cnt[s][w] = (m_cnt[s][w] < 3) ? m_cnt[s][w] + 1 : 3;
            m_tgt[s][w] = tgt;
         end else begin
            m_cnt[s][w] = (m_cnt[s][w] > 0) ? m_cnt[s][w] - 1 : 0;
         end
         m_stamp[s][w] = now_t;
      end else if (tk) begin
         if (!m_valid[s][0]) w = 0;
         else if (!m_valid[s][1]) w = 1;
         else w = (m_stamp[s][0] <= m_stamp[s][1]) ? 0 : 1;
         m_valid[s][w] = 1'b1;
         m_pc[s][w]    = pc;
         m_tgt[s][w]   = tgt;
         m_cnt[s][w]   = 2;
         m_stamp[s][w] = now_t;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_left = 0;
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < 2; w++) begin
               m_valid[s][w] = 1'b0;
               m_stamp[s][w] = 0;
            end
      end else begin
         now_t++;
         if (clr_left > 0) begin
            for (int w = 0; w < 2; w++) m_valid[SETS - clr_left][w] = 1'b0;
            clr_left--;
         end else begin
            if (bus.upd_valid)
               model_update(bus.upd_pc, bus.upd_target, bus.upd_taken);
            if (bus.inval_req) clr_left = SETS;
         end
      end
   end

   // Compare process.
   always @(negedge clk) begin
      int w, s;
      logic e_hit, e_tk;
      logic [15:0] e_tgt;
      e_hit = 1'b0;
      e_tk  = 1'b0;
      e_tgt = 16'h0;
      w = find_way(bus.lookup_pc);
      s = set_of(bus.lookup_pc);
      if (clr_left == 0 && w >= 0) begin
         e_hit = 1'b1;
         e_tk  = (m_cnt[s][w] >= 2);
         e_tgt = m_tgt[s][w];
      end
      check("cmp_hit", 32'(bus.lookup_hit), 32'(e_hit));
      check("cmp_taken", 32'(bus.lookup_taken), 32'(e_tk));
      check("cmp_target", 32'(bus.lookup_target), 32'(e_tgt));
      check("cmp_clearing", 32'(bus.clearing), 32'(clr_left > 0));
      check("cmp_ready", 32'(bus.upd_ready), 32'(!rst && clr_left == 0));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(logic [15:0] pc, logic [15:0] tgt, logic tk);
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = pc;
      bus.upd_target = tgt;
      bus.upd_taken  = tk;
      step();
      bus.upd_valid  = 1'b0;
   endtask

   task automatic look(string name, logic [15:0] pc, logic hit, logic tk,
                       logic [15:0] tgt);
      bus.lookup_pc = pc;
      #2;
      check({name, "_hit"}, 32'(bus.lookup_hit), 32'(hit));
      check({name, "_taken"}, 32'(bus.lookup_taken), 32'(tk));
      check({name, "_target"}, 32'(bus.lookup_target), 32'(tgt));
   endtask

   task automatic do_clear();
      bus.inval_req = 1'b1;
      step();
      bus.inval_req = 1'b0;
      for (int i = 0; i < 20 && bus.clearing; i++) step();
      check("clear_done", 32'(bus.clearing), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int ncl;
      bus.lookup_pc  = 16'h3004;
      bus.upd_valid  = 1'b0;
      bus.upd_pc     = 16'h0;
      bus.upd_target = 16'h0;
      bus.upd_taken  = 1'b0;
      bus.inval_req  = 1'b0;
      rst = 1'b1;
      repeat (3) step();
      check("rst_hit", 32'(bus.lookup_hit), 32'd0);
      check("rst_target", 32'(bus.lookup_target), 32'd0);
      check("rst_ready", 32'(bus.upd_ready), 32'd0);
      check("rst_clearing", 32'(bus.clearing), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(bus.upd_ready), 32'd1);
      look("post_rst", 16'h3004, 1'b0, 1'b0, 16'h0000);

      upd(16'h3004, 16'h3020, 1'b1);
      look("first", 16'h3004, 1'b1, 1'b1, 16'h3020);

      repeat (3) upd(16'h3004, 16'h3020, 1'b1);
      look("sat3", 16'h3004, 1'b1, 1'b1, 16'h3020);
      repeat (2) upd(16'h3004, 16'h3ffe, 1'b0);
      look("two_nt", 16'h3004, 1'b1, 1'b0, 16'h3020);
      upd(16'h3004, 16'h3020, 1'b1);
      look("retaken", 16'h3004, 1'b1, 1'b1, 16'h3020);

      bus.inval_req  = 1'b1;
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = 16'h7000;
      bus.upd_target = 16'h7070;
      bus.upd_taken  = 1'b1;
      step();
      bus.inval_req = 1'b0;
      bus.upd_pc    = 16'h6004;
      ncl = 0;
      for (int i = 0; i < 20; i++) begin
         #2;
         if (bus.clearing) begin
            ncl++;
            check("clr_ready", 32'(bus.upd_ready), 32'd0);
         end else begin
            bus.upd_valid = 1'b0;
         end
         step();
      end
      bus.upd_valid = 1'b0;
      check("clear_len", 32'(ncl), 32'd8);
      look("clr_3004", 16'h3004, 1'b0, 1'b0, 16'h0000);
      look("clr_6004", 16'h6004, 1'b0, 1'b0, 16'h0000);
      look("clr_7000", 16'h7000, 1'b0, 1'b0, 16'h0000);

      upd(16'h3004, 16'h3030, 1'b1);
      upd(16'h4004, 16'h4040, 1'b1);
      upd(16'h5004, 16'h5050, 1'b1);
      look("lru_3004", 16'h3004, 1'b0, 1'b0, 16'h0000);
      look("lru_4004", 16'h4004, 1'b1, 1'b1, 16'h4040);
      look("lru_5004", 16'h5004, 1'b1, 1'b1, 16'h5050);

      do_clear();
      upd(16'h3004, 16'h3030, 1'b1);
      upd(16'h4004, 16'h4040, 1'b1);
      upd(16'h3004, 16'h3030, 1'b1);
      upd(16'h5004, 16'h5050, 1'b1);
      look("touch_3004", 16'h3004, 1'b1, 1'b1, 16'h3030);
      look("touch_4004", 16'h4004, 1'b0, 1'b0, 16'h0000);
      look("touch_5004", 16'h5004, 1'b1, 1'b1, 16'h5050);

      bus.inval_req = 1'b1;
      step();
      bus.inval_req = 1'b0;
      step();
      step();
      check("mid_clearing", 32'(bus.clearing), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_clearing", 32'(bus.clearing), 32'd0);
      check("abort_ready", 32'(bus.upd_ready), 32'd0);
      step();
      rst = 1'b0;
      step();

      bus.lookup_pc  = 16'h3004;
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = 16'h3004;
      bus.upd_target = 16'h3020;
      bus.upd_taken  = 1'b1;
      #2;
      check("same_cyc_hit", 32'(bus.lookup_hit), 32'd0);
      step();
      bus.upd_valid = 1'b0;
      look("next_cyc", 16'h3004, 1'b1, 1'b1, 16'h3020);

      step();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
